// File: rtl/dom_pk_pkg.sv
// Shared constants, FSM state type and code-legality helper for the DOM_PK key-state tracker.
package dom_pk_pkg;

  localparam int          CODE_W         = 16;
  localparam logic [31:0] DOM_PK_UNKNOWN = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  // A code is usable when it is not UNKNOWN and fits in the stored width.
  function automatic logic code_legal(input logic [31:0] code, input int code_w);
    return (code != DOM_PK_UNKNOWN) && ((code >> code_w) == 32'd0);
  endfunction

endpackage

// File: rtl/dom_pk_key_state_if.sv
// Upstream key-code handshake plus downstream key-state event channel.
interface dom_pk_key_state_if #(
  parameter int CODE_W = dom_pk_pkg::CODE_W
);
  logic              in_valid;
  logic              in_stall;
  logic [31:0]       in_code;
  logic              in_down;
  logic              evt_valid;
  logic              evt_stall;
  logic [CODE_W-1:0] evt_code;
  logic              evt_down;

  modport master (
    output in_valid, in_code, in_down, evt_stall,
    input  in_stall, evt_valid, evt_code, evt_down
  );

  modport slave (
    input  in_valid, in_code, in_down, evt_stall,
    output in_stall, evt_valid, evt_code, evt_down
  );
endinterface

// File: rtl/dom_pk_slot_table.sv
// Pressed-key slot storage: valid bits and codes, one indexed read port, one write/invalidate port.
module dom_pk_slot_table #(
  parameter int NUM_SLOTS = 8,
  parameter int CODE_W    = 16,
  parameter int IDX_W     = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [CODE_W-1:0] rd_code_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_valid_i,
  input  logic [CODE_W-1:0] wr_code_i
);
  import dom_pk_pkg::*;

  logic [NUM_SLOTS-1:0] valid_q;
  logic [CODE_W-1:0]    code_q [NUM_SLOTS];

  // Slot state; stale codes behind a cleared valid bit are never matched.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        code_q[i] <= '0;
      end
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      if (wr_valid_i) begin
        code_q[wr_idx_i] <= wr_code_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_code_o  = code_q[rd_idx_i];

endmodule

// File: rtl/dom_pk_key_state.sv
// Tracks currently pressed DOM_PK keys and emits one event per press/release state change.
module dom_pk_key_state #(
  parameter int NUM_SLOTS = 8,
  parameter int CODE_W    = dom_pk_pkg::CODE_W
) (
  input  logic                           clock,
  input  logic                           resetn,
  dom_pk_key_state_if.slave              bus,
  input  logic                           clear,
  output logic [$clog2(NUM_SLOTS+1)-1:0] pressed_count,
  output logic                           overflow,
  output logic                           invalid_code
);
  import dom_pk_pkg::*;

  localparam int               IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int               CNT_W    = $clog2(NUM_SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_SLOTS);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              down_q, down_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
  logic              free_q, free_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              inv_q, inv_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              evt_down_q, evt_down_d;

  logic              rd_valid_s;
  logic [CODE_W-1:0] rd_code_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              wr_valid_s;

  dom_pk_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .CODE_W    (CODE_W),
    .IDX_W     (IDX_W)
  ) u_table (
    .clock      (clock),
    .resetn     (resetn),
    .clear_i    (clear),
    .rd_idx_i   (idx_q),
    .rd_valid_o (rd_valid_s),
    .rd_code_o  (rd_code_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (wr_idx_s),
    .wr_valid_i (wr_valid_s),
    .wr_code_i  (code_q)
  );

  // Next-state logic: clear pre-empts everything, otherwise one slot per SEARCH cycle.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    down_d      = down_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    inv_d       = inv_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_down_d  = evt_down_q;
    wr_en_s     = 1'b0;
    wr_idx_s    = hit_idx_q;
    wr_valid_s  = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      inv_d       = 1'b0;
      evt_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && code_legal(bus.in_code, CODE_W)) begin
            code_d  = bus.in_code[CODE_W-1:0];
            down_d  = bus.in_down;
            idx_d   = '0;
            hit_d   = 1'b0;
            free_d  = 1'b0;
            state_d = ST_SEARCH;
          end else if (bus.in_valid) begin
            inv_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEARCH: begin
          if (rd_valid_s && (rd_code_s == code_q)) begin
            hit_d     = 1'b1;
            hit_idx_d = idx_q;
            state_d   = ST_UPDATE;
          end else begin
            if (!rd_valid_s && !free_q) begin
              free_d     = 1'b1;
              free_idx_d = idx_q;
            end else begin
              free_d = free_q;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_UPDATE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_UPDATE: begin
          state_d = ST_IDLE;
          if (down_q && !hit_q && free_q && (cnt_q != CNT_MAX)) begin
            wr_en_s     = 1'b1;
            wr_idx_s    = free_idx_q;
            wr_valid_s  = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            evt_valid_d = 1'b1;
            evt_code_d  = code_q;
            evt_down_d  = 1'b1;
            state_d     = ST_EMIT;
          end else if (down_q && !hit_q) begin
            ovf_d = 1'b1;
          end else if (!down_q && hit_q && (cnt_q != '0)) begin
            wr_en_s     = 1'b1;
            wr_idx_s    = hit_idx_q;
            wr_valid_s  = 1'b0;
            cnt_d       = cnt_q - CNT_W'(1);
            evt_valid_d = 1'b1;
            evt_code_d  = code_q;
            evt_down_d  = 1'b0;
            state_d     = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (!bus.evt_stall) begin
            evt_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_EMIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      down_q      <= 1'b0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      down_q      <= down_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      free_q      <= free_d;
      free_idx_q  <= free_idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_down_q  <= evt_down_d;
    end
  end

  // Clear must block acceptance in the same cycle, so it is folded in combinationally.
  assign bus.in_stall   = (state_q != ST_IDLE) || clear;
  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_code   = evt_code_q;
  assign bus.evt_down   = evt_down_q;
  assign pressed_count  = cnt_q;
  assign overflow       = ovf_q;
  assign invalid_code   = inv_q;

endmodule

// File: tb/tb_dom_pk_key_state.sv
// Self-checking bench: directed vector table, clear/reset corner sequences, randomized run vs slot-list model.
module tb_dom_pk_key_state;
  localparam int N      = 8;
  localparam int CODE_W = 16;

  logic       clock;
  logic       resetn;
  logic       clear;
  logic [3:0] pressed_count;
  logic       overflow;
  logic       invalid_code;

  int checks = 0;
  int errors = 0;

  dom_pk_key_state_if #(.CODE_W(CODE_W)) bus ();

  dom_pk_key_state #(.NUM_SLOTS(N), .CODE_W(CODE_W)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .bus           (bus),
    .clear         (clear),
    .pressed_count (pressed_count),
    .overflow      (overflow),
    .invalid_code  (invalid_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] code;
    logic        down;
    int          stall;
    logic        evt;
    int          edges;
    int          cnt;
    logic        ovf;
    logic        inv;
  } vec_t;

  vec_t vecs[17];

  // Reference model: plain list of held keys in slot order.
  logic [CODE_W-1:0] m_code[N];
  bit                m_val[N];
  int                m_cnt;
  bit                m_ovf;
  bit                m_inv;

  function automatic vec_t mk(input logic [31:0] code, input logic down, input int stall,
                              input logic evt, input int edges, input int cnt,
                              input logic ovf, input logic inv);
    vec_t v;
    v.code = code; v.down = down; v.stall = stall; v.evt = evt;
    v.edges = edges; v.cnt = cnt; v.ovf = ovf; v.inv = inv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One key transaction, expectations supplied by caller.
  task automatic run_txn(input string tag, input logic [31:0] code, input logic down,
                         input int stall, input logic exp_evt, input int exp_edges,
                         input int exp_cnt, input logic exp_ovf, input logic exp_inv);
    int n;
    logic [CODE_W-1:0] held_code;
    logic held_down;
    chk({tag, "/stall_pre"}, bus.in_stall, 0);
    bus.evt_stall = (stall > 0);
    bus.in_valid  = 1'b1;
    bus.in_code   = code;
    bus.in_down   = down;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!(bus.evt_valid || !bus.in_stall) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "/latency"}, n, exp_edges);
    chk({tag, "/evt_valid"}, bus.evt_valid, exp_evt);
    if (bus.evt_valid) begin
      if (exp_evt) begin
        chk({tag, "/evt_code"}, bus.evt_code, code[CODE_W-1:0]);
        chk({tag, "/evt_down"}, bus.evt_down, down);
      end
      held_code = bus.evt_code;
      held_down = bus.evt_down;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk({tag, "/hold_valid"}, bus.evt_valid, 1);
        chk({tag, "/hold_code"}, bus.evt_code, held_code);
        chk({tag, "/hold_down"}, bus.evt_down, held_down);
        chk({tag, "/hold_stall"}, bus.in_stall, 1);
      end
      bus.evt_stall = 1'b0;
      tick();
      chk({tag, "/evt_done"}, bus.evt_valid, 0);
      chk({tag, "/idle"}, bus.in_stall, 0);
    end
    bus.evt_stall = 1'b0;
    chk({tag, "/count"}, pressed_count, exp_cnt);
    chk({tag, "/overflow"}, overflow, exp_ovf);
    chk({tag, "/invalid"}, invalid_code, exp_inv);
  endtask

  task automatic model_step(input logic [31:0] code, input logic down,
                            output logic evt, output int edges);
    int hit;
    int fr;
    evt = 1'b0;
    if (code == 32'd0 || (code >> CODE_W) != 32'd0) begin
      m_inv = 1'b1;
      edges = 0;
    end else begin
      hit = -1;
      fr  = -1;
      for (int i = 0; i < N; i++) begin
        if (hit < 0 && m_val[i] && m_code[i] == code[CODE_W-1:0]) hit = i;
        if (fr < 0 && !m_val[i]) fr = i;
      end
      edges = 2 + ((hit >= 0) ? hit : N - 1);
      if (down && hit < 0 && fr >= 0) begin
        m_val[fr] = 1'b1;
        m_code[fr] = code[CODE_W-1:0];
        m_cnt++;
        evt = 1'b1;
      end else if (down && hit < 0) begin
        m_ovf = 1'b1;
      end else if (!down && hit >= 0) begin
        m_val[hit] = 1'b0;
        m_cnt--;
        evt = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic evt;
    int edges;
    logic [31:0] code;
    logic down;
    int stall;
    int r;

    vecs[0]  = mk(32'h0000_001E, 1'b1, 0, 1'b1, 9, 1, 1'b0, 1'b0);
    vecs[1]  = mk(32'h0000_001E, 1'b1, 0, 1'b0, 2, 1, 1'b0, 1'b0);
    vecs[2]  = mk(32'h0000_001E, 1'b0, 5, 1'b1, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      vecs[3+i] = mk(32'(i + 1), 1'b1, i % 2, 1'b1, 9, i + 1, 1'b0, 1'b0);
    end
    vecs[11] = mk(32'h0000_0010, 1'b1, 0, 1'b0, 9, 8, 1'b1, 1'b0);
    vecs[12] = mk(32'h0000_0003, 1'b0, 0, 1'b1, 4, 7, 1'b1, 1'b0);
    vecs[13] = mk(32'h0000_0010, 1'b1, 1, 1'b1, 9, 8, 1'b1, 1'b0);
    vecs[14] = mk(32'h0000_0010, 1'b0, 0, 1'b1, 4, 7, 1'b1, 1'b0);
    vecs[15] = mk(32'h0001_001E, 1'b1, 0, 1'b0, 0, 7, 1'b1, 1'b1);
    vecs[16] = mk(32'h0000_0000, 1'b1, 0, 1'b0, 0, 7, 1'b1, 1'b1);

    resetn = 1'b0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code = 32'd0;
    bus.in_down = 1'b0;
    bus.evt_stall = 1'b0;
    repeat (3) tick();
    chk("rst/in_stall", bus.in_stall, 0);
    chk("rst/evt_valid", bus.evt_valid, 0);
    chk("rst/evt_code", bus.evt_code, 0);
    chk("rst/evt_down", bus.evt_down, 0);
    chk("rst/count", pressed_count, 0);
    chk("rst/overflow", overflow, 0);
    chk("rst/invalid", invalid_code, 0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].code, vecs[i].down, vecs[i].stall,
              vecs[i].evt, vecs[i].edges, vecs[i].cnt, vecs[i].ovf, vecs[i].inv);
    end

    // clear while an event is held in EMIT
    bus.evt_stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code = 32'h0000_0020;
    bus.in_down = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.evt_valid && n < 40) begin
      tick();
      n++;
    end
    chk("clr_emit/pre_valid", bus.evt_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.evt_stall = 1'b0;
    #1;
    chk("clr_emit/evt_valid", bus.evt_valid, 0);
    chk("clr_emit/count", pressed_count, 0);
    chk("clr_emit/overflow", overflow, 0);
    chk("clr_emit/invalid", invalid_code, 0);
    chk("clr_emit/in_stall", bus.in_stall, 0);
    tick();
    run_txn("clr_emit/next", 32'h0000_0020, 1'b1, 0, 1'b1, 9, 1, 1'b0, 1'b0);

    // clear and in_valid together in IDLE: the input must be ignored
    bus.in_valid = 1'b1;
    bus.in_code = 32'h0000_0030;
    bus.in_down = 1'b1;
    clear = 1'b1;
    #1;
    chk("clr_valid/stall_during", bus.in_stall, 1);
    tick();
    bus.in_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("clr_valid/in_stall", bus.in_stall, 0);
    chk("clr_valid/count", pressed_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.evt_valid || bus.in_stall) seen = 1'b1;
    end
    chk("clr_valid/no_activity", seen, 0);

    // reset in the middle of a search
    bus.in_valid = 1'b1;
    bus.in_code = 32'h0000_0040;
    bus.in_down = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    chk("rst_mid/in_stall", bus.in_stall, 0);
    chk("rst_mid/evt_valid", bus.evt_valid, 0);
    chk("rst_mid/count", pressed_count, 0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.evt_valid) seen = 1'b1;
    end
    chk("rst_mid/no_event", seen, 0);

    // randomized run against the model
    for (int i = 0; i < N; i++) begin
      m_val[i] = 1'b0;
      m_code[i] = '0;
    end
    m_cnt = 0;
    m_ovf = 1'b0;
    m_inv = 1'b0;
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 19);
      if (r == 16) code = 32'd0;
      else if (r == 17) code = 32'h0001_0005;
      else code = 32'($urandom_range(1, 10));
      down = ($urandom_range(0, 4) < 3);
      stall = $urandom_range(0, 2);
      model_step(code, down, evt, edges);
      run_txn($sformatf("rnd%0d", t), code, down, stall, evt, edges, m_cnt, m_ovf, m_inv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dom_pk_key_state.md
DOM_PK_KEY_STATE -- requirements
Module: dom_pk_key_state

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clock and resetn.
REQ-002 Parameter NUM_SLOTS, default 8: number of simultaneously tracked pressed keys.
REQ-003 Parameter CODE_W, default 16: stored DOM_PK code width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  input code valid; driven by the upstream key-code stage's done.
REQ-007 in_stall  out  1  backpressure to the upstream stage; it drives that stage's stall.
REQ-008 in_code  in  32  DOM_PK code; takes the upstream returndata.
REQ-009 in_down  in  1  1 = keydown, 0 = keyup.
REQ-010 clear  in  1  synchronous release-all, e.g. on focus loss.
REQ-011 evt_valid  out  1  key-state change event valid.
REQ-012 evt_stall  in  1  downstream backpressure.
REQ-013 evt_code  out  CODE_W  code of the changed key.
REQ-014 evt_down  out  1  1 = press, 0 = release.
REQ-015 pressed_count  out  clog2(NUM_SLOTS+1)  number of occupied slots.
REQ-016 overflow  out  1  sticky: a keydown was dropped because the table was full.
REQ-017 invalid_code  out  1  sticky: an illegal code was dropped.

Function
REQ-018 FSM states SHALL be IDLE, SEARCH, UPDATE and EMIT; in_stall SHALL be 0 only in IDLE with clear=0.
REQ-019 IDLE: in_valid=1 with in_stall=0 SHALL accept the input and latch in_code[CODE_W-1:0] and in_down.
REQ-020 An input with in_code==0 (DOM_PK_UNKNOWN) or in_code[31:CODE_W]!=0 SHALL set invalid_code, be dropped, and leave the FSM in IDLE.
REQ-021 A legal input SHALL go to SEARCH at index 0.
REQ-022 SEARCH SHALL examine one slot per cycle, recording the lowest-index free slot.
REQ-023 SEARCH SHALL exit to UPDATE on a valid slot whose code matches (hit) or after slot NUM_SLOTS-1 (miss).
REQ-024 UPDATE, down and hit (autorepeat): no event; return to IDLE.
REQ-025 UPDATE, down, miss, free slot found: write code to the lowest free slot, increment pressed_count, go to EMIT with evt_down=1.
REQ-026 UPDATE, down, miss, table full: set overflow, no event, return to IDLE.
REQ-027 UPDATE, up and hit: invalidate the slot, decrement pressed_count, go to EMIT with evt_down=0.
REQ-028 UPDATE, up and miss: no event; return to IDLE.
REQ-029 EMIT: evt_valid=1 with evt_code and evt_down stable until a cycle with evt_stall=0, then IDLE.
REQ-030 Latency: accept at cycle T with a hit at slot k gives SEARCH T+1..T+1+k, UPDATE T+2+k, evt_valid from T+3+k; a miss uses k=NUM_SLOTS-1.
REQ-031 clear=1 SHALL have priority in every state and take effect in the next cycle: all slots invalid, pressed_count=0, overflow=0, invalid_code=0, any in-flight operation and pending event dropped, evt_valid=0, FSM in IDLE.
REQ-032 in_valid and clear high in the same IDLE cycle: clear wins and the input is not accepted.
REQ-033 pressed_count SHALL never exceed NUM_SLOTS or underflow below 0.

Reset
REQ-034 While resetn=0 at a rising edge, the FSM SHALL enter IDLE and all slots SHALL become invalid.
REQ-035 While resetn=0 at a rising edge, in_stall, evt_valid, evt_code, evt_down, pressed_count, overflow and invalid_code SHALL all be 0.
REQ-036 Reset mid-operation SHALL discard the latched input and any pending event.

Structure
REQ-037 Package dom_pk_pkg SHALL hold CODE_W, the DOM_PK_UNKNOWN constant (0) and the FSM state enum.
REQ-038 Slot valid bits and code registers SHALL be in sub-module dom_pk_slot_table, with one indexed read port, one write/invalidate port and a clear-all input.

Verification
REQ-039 IDLE, empty table; keydown 0x001E at T -> evt_valid at T+10 with evt_code=0x001E and evt_down=1; pressed_count=1.
REQ-040 Second keydown 0x001E -> no event, pressed_count=1, in_stall low again at T+3.
REQ-041 Keydown 0x0001..0x0008, then keydown 0x0010 -> overflow=1, no event, count=8; then keyup 0x0003, then keydown 0x0010 -> 0x0010 press event and slot 2 reused.
REQ-042 Keyup 0x001E with evt_stall high for 5 cycles -> evt_valid and its data held stable and in_stall=1; event completes on the first evt_stall=0 cycle.
REQ-043 in_code 0x0001001E, then in_code 0 -> invalid_code=1, no events, each input accepted in 1 cycle.
REQ-044 clear asserted during EMIT -> evt_valid=0 next cycle, pressed_count=0, overflow=0, next input accepted normally.
